// File: rtl/pe_inst_sequencer.sv
// Per-PE job sequencer: drives the PE Inst fields (dval/start/reset/stall), counts MAIN
// handshakes into passes and throttles the PE on free psum output-buffer credits.
module pe_inst_sequencer #(
  parameter int unsigned MAC_W  = 16,
  parameter int unsigned PASS_W = 8,
  parameter int unsigned CREDIT = 4
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        Job_rdy,
  output logic                        Job_ack,
  input  logic [MAC_W-1:0]            i_job_nmac,
  input  logic [PASS_W-1:0]           i_job_npass,
  input  logic                        i_main_fire,
  input  logic                        i_credit_ret,
  input  logic                        i_abort,
  output logic                        o_inst_dval,
  output logic                        o_inst_start,
  output logic                        o_inst_reset,
  output logic                        o_inst_stall,
  output logic                        o_pass_done,
  output logic [PASS_W-1:0]           o_pass_idx,
  output logic                        o_done,
  output logic                        o_aborted,
  output logic                        o_busy,
  output logic [$clog2(CREDIT+1)-1:0] o_credit
);

  localparam int unsigned CW = $clog2(CREDIT + 1);
  localparam logic [CW-1:0] CreditMax = CW'(CREDIT);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StStart = 3'd1;
  localparam logic [2:0] StRun   = 3'd2;
  localparam logic [2:0] StStall = 3'd3;
  localparam logic [2:0] StFin   = 3'd4;

  logic [2:0]        state_q, state_d;
  logic [MAC_W-1:0]  mac_q, mac_d;
  logic [MAC_W-1:0]  nmac_q, nmac_d;
  logic [PASS_W-1:0] npass_q, npass_d;
  logic [PASS_W-1:0] idx_q, idx_d;
  logic [CW-1:0]     credit_q, credit_d;
  logic              job_ack_q, job_ack_d;
  logic              dval_q, dval_d;
  logic              start_q, start_d;
  logic              reset_q, reset_d;
  logic              stall_q, stall_d;
  logic              pass_done_q, pass_done_d;
  logic              done_q, done_d;
  logic              aborted_q, aborted_d;
  logic              busy_q, busy_d;

  logic last_mac;
  logic last_pass;
  logic pass_end;
  logic zero_job;
  logic abort_act;

  assign last_mac  = (mac_q == nmac_q - MAC_W'(1));
  assign last_pass = (idx_q == npass_q - PASS_W'(1));
  assign abort_act = i_abort && (state_q != StIdle);
  // Abort wins over a pass end landing in the same cycle.
  assign pass_end  = (state_q == StRun) && i_main_fire && last_mac && !i_abort;
  assign zero_job  = (i_job_nmac == '0) || (i_job_npass == '0);

  // Simultaneous consume and return cancel; a return at full credit is dropped.
  always_comb begin
    credit_d = credit_q;
    if (pass_end && !i_credit_ret) begin
      credit_d = credit_q - CW'(1);
    end else if (!pass_end && i_credit_ret && (credit_q != CreditMax)) begin
      credit_d = credit_q + CW'(1);
    end
  end

  always_comb begin
    state_d     = state_q;
    mac_d       = mac_q;
    nmac_d      = nmac_q;
    npass_d     = npass_q;
    idx_d       = idx_q;
    dval_d      = 1'b0;
    start_d     = 1'b0;
    reset_d     = 1'b0;
    stall_d     = 1'b0;
    pass_done_d = 1'b0;
    done_d      = 1'b0;
    aborted_d   = 1'b0;

    if (abort_act) begin
      state_d   = StIdle;
      mac_d     = '0;
      idx_d     = '0;
      dval_d    = 1'b1;
      reset_d   = 1'b1;
      aborted_d = 1'b1;
    end else begin
      case (state_q)
        StIdle: begin
          if (Job_rdy && job_ack_q) begin
            nmac_d  = i_job_nmac;
            npass_d = i_job_npass;
            mac_d   = '0;
            idx_d   = '0;
            if (zero_job) begin
              // Nothing to run: report completion without touching the PE controller.
              state_d = StFin;
              done_d  = 1'b1;
            end else begin
              state_d = StStart;
              dval_d  = 1'b1;
              start_d = 1'b1;
              reset_d = 1'b1;
            end
          end
        end
        StStart: begin
          if (credit_q != '0) begin
            state_d = StRun;
          end else begin
            state_d = StStall;
            dval_d  = 1'b1;
            stall_d = 1'b1;
          end
        end
        StRun: begin
          if (pass_end) begin
            mac_d       = '0;
            pass_done_d = 1'b1;
            if (last_pass) begin
              state_d = StFin;
              dval_d  = 1'b1;
              reset_d = 1'b1;
              done_d  = 1'b1;
            end else begin
              idx_d = idx_q + PASS_W'(1);
              if (credit_d == '0) begin
                state_d = StStall;
                dval_d  = 1'b1;
                stall_d = 1'b1;
              end
            end
          end else if (i_main_fire) begin
            mac_d = mac_q + MAC_W'(1);
          end
        end
        StStall: begin
          if (credit_q != '0) begin
            state_d = StRun;
            dval_d  = 1'b1;
          end
        end
        StFin: begin
          state_d = StIdle;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  assign job_ack_d = (state_d == StIdle);
  assign busy_d    = (state_d != StIdle);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= StIdle;
      mac_q       <= '0;
      nmac_q      <= '0;
      npass_q     <= '0;
      idx_q       <= '0;
      credit_q    <= CreditMax;
      job_ack_q   <= 1'b1;
      dval_q      <= 1'b0;
      start_q     <= 1'b0;
      reset_q     <= 1'b0;
      stall_q     <= 1'b0;
      pass_done_q <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mac_q       <= mac_d;
      nmac_q      <= nmac_d;
      npass_q     <= npass_d;
      idx_q       <= idx_d;
      credit_q    <= credit_d;
      job_ack_q   <= job_ack_d;
      dval_q      <= dval_d;
      start_q     <= start_d;
      reset_q     <= reset_d;
      stall_q     <= stall_d;
      pass_done_q <= pass_done_d;
      done_q      <= done_d;
      aborted_q   <= aborted_d;
      busy_q      <= busy_d;
    end
  end

  assign Job_ack      = job_ack_q;
  assign o_inst_dval  = dval_q;
  assign o_inst_start = start_q;
  assign o_inst_reset = reset_q;
  assign o_inst_stall = stall_q;
  assign o_pass_done  = pass_done_q;
  assign o_pass_idx   = idx_q;
  assign o_done       = done_q;
  assign o_aborted    = aborted_q;
  assign o_busy       = busy_q;
  assign o_credit     = credit_q;

  // RUN is only ever entered with a free slot, so it never sits there at zero credit.
  a_credit_bound: assert property (@(posedge i_clk) disable iff (i_rst) credit_q <= CreditMax);
  a_run_credit:   assert property (@(posedge i_clk) disable iff (i_rst)
                                   (state_q == StRun) |-> (credit_q != '0));

endmodule

// File: tb/tb_pe_inst_sequencer.sv
// Scoreboard bench for pe_inst_sequencer: expected Inst/pulse events are queued per cycle as
// stimulus is driven; every cycle without a queued event must show all of them low.
module tb_pe_inst_sequencer;

  localparam int unsigned MAC_W  = 16;
  localparam int unsigned PASS_W = 8;
  localparam int unsigned CREDIT = 4;
  localparam int unsigned CW     = $clog2(CREDIT + 1);

  // {dval, start, reset, stall, pass_done, done, aborted}
  localparam logic [6:0] EvDval  = 7'b1000000;
  localparam logic [6:0] EvStart = 7'b0100000;
  localparam logic [6:0] EvReset = 7'b0010000;
  localparam logic [6:0] EvStall = 7'b0001000;
  localparam logic [6:0] EvPd    = 7'b0000100;
  localparam logic [6:0] EvDone  = 7'b0000010;
  localparam logic [6:0] EvAbort = 7'b0000001;

  logic              clk = 1'b0;
  logic              i_rst = 1'b1;
  logic              Job_rdy = 1'b0;
  logic              Job_ack;
  logic [MAC_W-1:0]  i_job_nmac = '0;
  logic [PASS_W-1:0] i_job_npass = '0;
  logic              i_main_fire = 1'b0;
  logic              i_credit_ret = 1'b0;
  logic              i_abort = 1'b0;
  logic              o_inst_dval, o_inst_start, o_inst_reset, o_inst_stall;
  logic              o_pass_done, o_done, o_aborted, o_busy;
  logic [PASS_W-1:0] o_pass_idx;
  logic [CW-1:0]     o_credit;
  logic [6:0]        obs;

  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;
  bit mon_en = 1'b0;

  typedef struct {
    int         cyc;
    logic [6:0] v;
    string      tag;
  } ev_t;
  ev_t sb_q[$];

  pe_inst_sequencer #(
    .MAC_W (MAC_W),
    .PASS_W(PASS_W),
    .CREDIT(CREDIT)
  ) u_dut (
    .i_clk       (clk),
    .i_rst       (i_rst),
    .Job_rdy     (Job_rdy),
    .Job_ack     (Job_ack),
    .i_job_nmac  (i_job_nmac),
    .i_job_npass (i_job_npass),
    .i_main_fire (i_main_fire),
    .i_credit_ret(i_credit_ret),
    .i_abort     (i_abort),
    .o_inst_dval (o_inst_dval),
    .o_inst_start(o_inst_start),
    .o_inst_reset(o_inst_reset),
    .o_inst_stall(o_inst_stall),
    .o_pass_done (o_pass_done),
    .o_pass_idx  (o_pass_idx),
    .o_done      (o_done),
    .o_aborted   (o_aborted),
    .o_busy      (o_busy),
    .o_credit    (o_credit)
  );

  assign obs = {o_inst_dval, o_inst_start, o_inst_reset, o_inst_stall,
                o_pass_done, o_done, o_aborted};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic void push(input int c, input logic [6:0] v, input string tag);
    ev_t e;
    e.cyc = c;
    e.v   = v;
    e.tag = tag;
    sb_q.push_back(e);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives a one-cycle job request in the current cycle; returns in the following cycle.
  task automatic accept(input int nmac, input int npass, output int t);
    t = cyc;
    check("job_ack_before_accept", Job_ack, 1);
    Job_rdy     = 1'b1;
    i_job_nmac  = MAC_W'(nmac);
    i_job_npass = PASS_W'(npass);
    if (nmac == 0 || npass == 0) push(t + 1, EvDone, "zero_done");
    else                         push(t + 1, EvDval | EvStart | EvReset, "start_inst");
    step();
    Job_rdy = 1'b0;
  endtask

  always @(negedge clk) begin
    logic [6:0] exp_v;
    string      tag;
    ev_t        e;
    if (mon_en) begin
      exp_v = '0;
      tag   = "inst_quiet";
      while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
        e = sb_q.pop_front();
        check({"sb_missed_", e.tag}, e.cyc, cyc);
      end
      if (sb_q.size() > 0 && sb_q[0].cyc == cyc) begin
        e     = sb_q.pop_front();
        exp_v = e.v;
        tag   = e.tag;
      end
      check(tag, obs, exp_v);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t;
    repeat (2) @(posedge clk);
    #1;
    i_rst  = 1'b0;
    mon_en = 1'b1;

    check("rst_job_ack", Job_ack, 1);
    check("rst_credit", o_credit, CREDIT);
    check("rst_busy", o_busy, 0);
    check("rst_pass_idx", o_pass_idx, 0);
    check("rst_inst", obs, 0);

    // Basic job: nmac=3, npass=2, continuous fires.
    accept(3, 2, t);
    push(t + 5, EvPd, "basic_pd0");
    push(t + 8, EvDval | EvReset | EvPd | EvDone, "basic_fin");
    check("basic_busy", o_busy, 1);
    check("basic_ack_low", Job_ack, 0);
    step();
    i_main_fire = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      if (i == 2) begin
        check("basic_idx1", o_pass_idx, 1);
        check("basic_credit3", o_credit, 3);
      end
    end
    i_main_fire = 1'b0;
    check("basic_credit_end", o_credit, 2);
    step();
    check("basic_ack_back", Job_ack, 1);
    check("basic_idle", o_busy, 0);

    // Single-MAC single-pass job accepted the cycle after FIN.
    accept(1, 1, t);
    push(t + 3, EvDval | EvReset | EvPd | EvDone, "one_fin");
    step();
    i_main_fire = 1'b1;
    step();
    i_main_fire = 1'b0;
    check("one_credit", o_credit, 1);
    step();

    // Credit stall: one credit left, nmac=2, npass=3; fire held high throughout.
    accept(2, 3, t);
    i_main_fire = 1'b1;
    push(t + 4,  EvDval | EvStall | EvPd, "stall_entry0");
    push(t + 8,  EvDval, "stall_resume0");
    push(t + 10, EvDval | EvStall | EvPd, "stall_entry1");
    push(t + 13, EvDval, "stall_resume1");
    push(t + 15, EvDval | EvReset | EvPd | EvDone, "stall_fin");
    repeat (3) step();
    check("stall_credit0", o_credit, 0);
    check("stall_idx1", o_pass_idx, 1);
    repeat (2) step();
    i_credit_ret = 1'b1;
    step();
    i_credit_ret = 1'b0;
    check("stall_credit_back", o_credit, 1);
    repeat (3) step();
    check("stall_idx2", o_pass_idx, 2);
    check("stall_credit0_again", o_credit, 0);
    step();
    i_credit_ret = 1'b1;
    step();
    i_credit_ret = 1'b0;
    repeat (4) step();
    i_main_fire = 1'b0;
    check("stall_credit_end", o_credit, 0);
    check("stall_ack", Job_ack, 1);

    i_credit_ret = 1'b1;
    step();
    i_credit_ret = 1'b0;
    check("refill_one", o_credit, 1);

    // Pass end and credit return together on the last free slot: no stall.
    accept(1, 2, t);
    push(t + 3, EvPd, "simul_pd");
    push(t + 4, EvDval | EvReset | EvPd | EvDone, "simul_fin");
    step();
    i_main_fire  = 1'b1;
    i_credit_ret = 1'b1;
    step();
    i_credit_ret = 1'b0;
    check("simul_credit", o_credit, 1);
    check("simul_idx", o_pass_idx, 1);
    check("simul_busy", o_busy, 1);
    step();
    i_main_fire = 1'b0;
    check("simul_credit_end", o_credit, 0);
    step();

    // Returns beyond CREDIT saturate.
    i_credit_ret = 1'b1;
    repeat (6) step();
    i_credit_ret = 1'b0;
    check("sat_credit", o_credit, CREDIT);

    // Abort at MAC count 1 of pass 1, coinciding with what would be the pass end.
    accept(2, 2, t);
    push(t + 4, EvPd, "abort_pd0");
    push(t + 6, EvDval | EvReset | EvAbort, "abort_inst");
    step();
    i_main_fire = 1'b1;
    repeat (3) step();
    check("abort_idx_pre", o_pass_idx, 1);
    i_abort = 1'b1;
    step();
    i_abort     = 1'b0;
    i_main_fire = 1'b0;
    check("abort_idx", o_pass_idx, 0);
    check("abort_credit", o_credit, 3);
    check("abort_idle", o_busy, 0);
    check("abort_ack", Job_ack, 1);
    i_abort = 1'b1;
    step();
    i_abort = 1'b0;
    step();
    check("idle_abort_ack", Job_ack, 1);

    // Zero-size jobs.
    accept(0, 5, t);
    check("zero_busy", o_busy, 1);
    check("zero_ack_low", Job_ack, 0);
    step();
    check("zero_ack_back", Job_ack, 1);
    accept(4, 0, t);
    step();
    check("zero_credit", o_credit, 3);
    check("sb_empty", sb_q.size(), 0);

    // Async reset while in STALL.
    accept(1, 4, t);
    push(t + 3, EvPd, "rst_pd0");
    push(t + 4, EvPd, "rst_pd1");
    push(t + 5, EvDval | EvStall | EvPd, "rst_stall_entry");
    step();
    i_main_fire = 1'b1;
    repeat (3) step();
    i_main_fire = 1'b0;
    check("pre_rst_credit", o_credit, 0);
    check("pre_rst_idx", o_pass_idx, 3);
    check("pre_rst_inst", obs, EvDval | EvStall | EvPd);
    mon_en = 1'b0;
    sb_q.delete();
    i_rst = 1'b1;
    #1;
    check("async_rst_inst", obs, 0);
    check("async_rst_ack", Job_ack, 1);
    check("async_rst_credit", o_credit, CREDIT);
    check("async_rst_busy", o_busy, 0);
    check("async_rst_idx", o_pass_idx, 0);
    step();
    i_rst = 1'b0;
    step();
    check("post_rst_ack", Job_ack, 1);
    check("post_rst_credit", o_credit, CREDIT);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
